keypad_scanner: RTL



---
 rtl/keypad_scanner.sv | 240 ++++++++++++++++++++++++
 1 files changed

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: row scan, debounce, last-digit latch and '#' check strobe.
// Define KEYPAD_AUTO_CHECK_EN to also fire the check strobe on every digit key.
module keypad_scanner #(
  parameter int SCAN_DIV           = 12000,
  parameter int DEBOUNCE_SCANS     = 5,
  parameter int CHECK_PULSE_CYCLES = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] col_n,
  output logic [3:0] row_n,
  output logic [3:0] keypad_digit,
  output logic       check_answer_n,
  output logic       key_held
);

  localparam int SW = $clog2(SCAN_DIV);
  localparam int DW = $clog2(DEBOUNCE_SCANS + 1);
  localparam int PW = $clog2(CHECK_PULSE_CYCLES);

`ifdef KEYPAD_AUTO_CHECK_EN
  localparam bit AutoCheck = 1'b1;
`else
  localparam bit AutoCheck = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_CAND,
    S_PRESSED,
    S_RELEASE
  } state_e;

  logic [3:0]    col_s1_q, col_s2_q;
  logic [SW-1:0] settle_q, settle_d;
  logic [1:0]    row_idx_q, row_idx_d;
  logic [3:0]    row_n_q, row_n_d;
  logic [15:0]   press_q, press_d;
  logic          eval_q, eval_d;

  state_e        state_q, state_d;
  logic [DW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [3:0]    cand_q, cand_d;

  logic          key_held_q, key_held_d;
  logic [3:0]    digit_q, digit_d;
  logic          pend_vld_q, pend_vld_d;
  logic [3:0]    pend_val_q, pend_val_d;
  logic          pend_dig_q, pend_dig_d;
  logic          auto_q, auto_d;
  logic          check_n_q, check_n_d;
  logic [PW-1:0] pcnt_q, pcnt_d;

  logic [4:0]    hits;
  logic [3:0]    code;
  logic          code_vld;
  logic          accept;
  logic          digit_act, star_act, hash_act;
  logic [3:0]    digit_val;

  always_comb begin
    settle_d  = settle_q + SW'(1);
    row_idx_d = row_idx_q;
    row_n_d   = row_n_q;
    press_d   = press_q;
    eval_d    = 1'b0;
    if (settle_q == SW'(SCAN_DIV - 1)) begin
      settle_d  = '0;
      row_idx_d = row_idx_q + 2'd1;
      row_n_d   = {row_n_q[2:0], row_n_q[3]};
      press_d[{row_idx_q, 2'b00} +: 4] = ~col_s2_q;
      eval_d    = (row_idx_q == 2'd3);
    end
  end

  // press_q holds one full scan; a single hit is the only valid code
  always_comb begin
    hits = '0;
    code = '0;
    for (int i = 0; i < 16; i++) begin
      if (press_q[i]) begin
        hits = hits + 5'd1;
        code = 4'(i);
      end
    end
    code_vld = eval_q && (hits == 5'd1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      cand_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cand_q  <= cand_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    cnt_inc = cnt_q + DW'(1);
    if (eval_q) begin
      unique case (state_q)
        S_IDLE: begin
          if (code_vld) begin
            cand_d  = code;
            cnt_d   = DW'(1);
            state_d = (DEBOUNCE_SCANS == 1) ? S_PRESSED : S_CAND;
          end
        end
        S_CAND: begin
          if (code_vld && code == cand_q) begin
            cnt_d = cnt_inc;
            if (cnt_inc == DW'(DEBOUNCE_SCANS)) state_d = S_PRESSED;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_PRESSED: begin
          if (!code_vld) begin
            cnt_d   = DW'(1);
            state_d = (DEBOUNCE_SCANS == 1) ? S_IDLE : S_RELEASE;
          end
        end
        S_RELEASE: begin
          if (code_vld) begin
            state_d = S_PRESSED;
          end else begin
            cnt_d = cnt_inc;
            if (cnt_inc == DW'(DEBOUNCE_SCANS)) state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    accept     = eval_q && (state_q == S_IDLE || state_q == S_CAND)
                 && (state_d == S_PRESSED);
    key_held_d = (state_d == S_PRESSED) || (state_d == S_RELEASE);
    digit_act  = 1'b0;
    star_act   = 1'b0;
    hash_act   = 1'b0;
    digit_val  = '0;
    if (accept) begin
      unique case (1'b1)
        (code[1:0] == 2'd3): begin
        end
        (code[1:0] != 2'd3 && code[3:2] != 2'd3): begin
          digit_act = 1'b1;
          digit_val = 4'(code[3:2]) * 4'd3 + 4'(code[1:0]) + 4'd1;
        end
        (code == 4'd12): star_act  = 1'b1;
        (code == 4'd13): digit_act = 1'b1;
        (code == 4'd14): hash_act  = 1'b1;
        default: begin
        end
      endcase
    end
  end

  // digit writes wait for the strobe to end so the main FPGA never sees them change under it
  always_comb begin
    digit_d    = digit_q;
    pend_vld_d = pend_vld_q;
    pend_val_d = pend_val_q;
    pend_dig_d = pend_dig_q;
    auto_d     = 1'b0;
    check_n_d  = check_n_q;
    pcnt_d     = pcnt_q;
    if (digit_act || star_act) begin
      if (check_n_q) begin
        digit_d = digit_val;
        auto_d  = AutoCheck & digit_act;
      end else begin
        pend_vld_d = 1'b1;
        pend_val_d = digit_val;
        pend_dig_d = digit_act;
      end
    end else if (pend_vld_q && check_n_q) begin
      digit_d    = pend_val_q;
      pend_vld_d = 1'b0;
      auto_d     = AutoCheck & pend_dig_q;
    end
    if (!check_n_q) begin
      if (pcnt_q == '0) check_n_d = 1'b1;
      else pcnt_d = pcnt_q - PW'(1);
    end else if (hash_act || auto_q) begin
      check_n_d = 1'b0;
      pcnt_d    = PW'(CHECK_PULSE_CYCLES - 1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      col_s1_q   <= 4'b1111;
      col_s2_q   <= 4'b1111;
      settle_q   <= '0;
      row_idx_q  <= '0;
      row_n_q    <= 4'b1110;
      press_q    <= '0;
      eval_q     <= 1'b0;
      key_held_q <= 1'b0;
      digit_q    <= '0;
      pend_vld_q <= 1'b0;
      pend_val_q <= '0;
      pend_dig_q <= 1'b0;
      auto_q     <= 1'b0;
      check_n_q  <= 1'b1;
      pcnt_q     <= '0;
    end else begin
      col_s1_q   <= col_n;
      col_s2_q   <= col_s1_q;
      settle_q   <= settle_d;
      row_idx_q  <= row_idx_d;
      row_n_q    <= row_n_d;
      press_q    <= press_d;
      eval_q     <= eval_d;
      key_held_q <= key_held_d;
      digit_q    <= digit_d;
      pend_vld_q <= pend_vld_d;
      pend_val_q <= pend_val_d;
      pend_dig_q <= pend_dig_d;
      auto_q     <= auto_d;
      check_n_q  <= check_n_d;
      pcnt_q     <= pcnt_d;
    end
  end

  assign row_n          = row_n_q;
  assign keypad_digit   = digit_q;
  assign check_answer_n = check_n_q;
  assign key_held       = key_held_q;

endmodule
